// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I execute/control slice: opcodes, ALU operations,
// writeback and immediate-format selects.
package rv32i_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSlt  = 4'b0101,
    AluSltu = 4'b0110,
    AluSll  = 4'b0111,
    AluSrl  = 4'b1000,
    AluSra  = 4'b1001
  } alu_op_e;

  // Writeback select
  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_MEM  = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  // Immediate format handed to the external sign-extender
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operation selected by funct3; sub_sra picks SUB/SRA where legal.
  function automatic alu_op_e funct3_to_alu_op(input logic [2:0] funct3, input logic sub_sra);
    alu_op_e op;
    unique case (funct3)
      3'b000:  op = sub_sra ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = sub_sra ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_exec_ctrl_adder.sv
// Plain wrap-around adder used for the PC+4 and branch-target paths.
module rv32i_exec_ctrl_adder #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/rv32i_exec_ctrl_alu.sv
// 32-bit RV32I ALU: add/sub, logic ops, signed/unsigned compare, shifts.
module rv32i_exec_ctrl_alu
  import rv32i_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  alu_op_e               alu_op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  // Operation select; compares produce 0 or 1 in the low bit.
  always_comb begin
    result = '0;
    case (alu_op)
      AluAdd:  result = op_a + op_b;
      AluSub:  result = op_a - op_b;
      AluAnd:  result = op_a & op_b;
      AluOr:   result = op_a | op_b;
      AluXor:  result = op_a ^ op_b;
      AluSlt:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      AluSltu: result = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
      AluSll:  result = op_a << shamt;
      AluSrl:  result = op_a >> shamt;
      AluSra:  result = $unsigned($signed(op_a) >>> shamt);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv32i_exec_ctrl.sv
// Single-cycle RV32I execute/control slice: PC register, PC adders, main/ALU
// decoder and ALU with operand-B mux. The PC is the only state.
module rv32i_exec_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  input  logic [DATA_WIDTH-1:0] imm_op,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  zero,
  output logic                  reg_wr_en,
  output logic                  mem_wr_en,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic                  alu_src
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];

  // Register indices and the rest of funct7 are consumed outside this slice.
  logic unused_instr;
  assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:7]};

  logic                  is_beq;
  logic                  is_bne;
  logic                  is_jal;
  logic                  pc_src;
  alu_op_e               alu_op;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] pc_target;
  logic [DATA_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] pc_q;

  // Main decoder: control signals and ALU operation from opcode/funct fields.
  always_comb begin
    reg_wr_en  = 1'b0;
    mem_wr_en  = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    result_src = RESULT_ALU;
    alu_op     = AluAdd;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_jal     = 1'b0;
    case (opcode)
      OP_R_TYPE: begin
        reg_wr_en = 1'b1;
        alu_op    = funct3_to_alu_op(funct3, funct7_5);
      end
      OP_I_ALU: begin
        reg_wr_en = 1'b1;
        alu_src   = 1'b1;
        // Bit 30 is immediate data for ADDI; it only selects SRAI vs SRLI.
        alu_op    = funct3_to_alu_op(funct3, funct7_5 && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        reg_wr_en  = 1'b1;
        alu_src    = 1'b1;
        result_src = RESULT_MEM;
      end
      OP_STORE: begin
        mem_wr_en = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        imm_src = IMM_B;
        alu_op  = AluSub;
        is_beq  = (funct3 == 3'b000);
        is_bne  = (funct3 == 3'b001);
      end
      OP_JAL: begin
        reg_wr_en  = 1'b1;
        alu_src    = 1'b1;
        imm_src    = IMM_J;
        result_src = RESULT_PC4;
        is_jal     = 1'b1;
      end
      default: ;
    endcase
  end

  assign op_b   = alu_src ? imm_op : rd2;
  assign pc_src = (is_beq & zero) | (is_bne & ~zero) | is_jal;

  rv32i_exec_ctrl_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op_a  (rd1),
    .op_b  (op_b),
    .alu_op(alu_op),
    .result(alu_out),
    .zero  (zero)
  );

  rv32i_exec_ctrl_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pc_plus4_adder (
    .a  (pc_q),
    .b  (DATA_WIDTH'(4)),
    .sum(pc_plus4)
  );

  rv32i_exec_ctrl_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pc_target_adder (
    .a  (pc_q),
    .b  (imm_op),
    .sum(pc_target)
  );

  assign next_pc = pc_src ? pc_target : pc_plus4;

  // PC register: async reset to RESET_PC, otherwise loads next_pc every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Directed bench for rv32i_exec_ctrl: a vector table for the combinational
// decode/ALU path plus hand-written sequences for PC, branches, JAL and reset.
module tb_rv32i_exec_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] alu_out;
  logic        zero;
  logic        reg_wr_en;
  logic        mem_wr_en;
  logic [1:0]  result_src;
  logic [1:0]  imm_src;
  logic        alu_src;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0080_00EF;
  localparam logic [31:0] BEQ = 32'h0020_8463;
  localparam logic [31:0] BNE = 32'h0020_9463;

  rv32i_exec_ctrl #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .rd1        (rd1),
    .rd2        (rd2),
    .imm_op     (imm_op),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .alu_out    (alu_out),
    .zero       (zero),
    .reg_wr_en  (reg_wr_en),
    .mem_wr_en  (mem_wr_en),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_src    (alu_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        z;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [1:0]  is;
    logic        as;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reset, then JAL from pc 0 so the PC lands on target after one edge.
  task automatic go_pc(input logic [31:0] target);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    instruction = JAL;
    imm_op = target;
    @(posedge clk);
    #1;
    chk("go_pc", pc, target);
  endtask

  initial begin
    //         instr          rd1           rd2           imm           alu_out     z  rw mw rs     is     as
    vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        32'd0,        32'd12,       0, 1, 0, 2'b00, 2'b00, 0}; // add
    vecs[1]  = '{32'h402081B3, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 0, 1, 0, 2'b00, 2'b00, 0}; // sub
    vecs[2]  = '{32'h4020D193, 32'h80000000, 32'd0,        32'd2,        32'hE0000000, 0, 1, 0, 2'b00, 2'b00, 1}; // srai
    vecs[3]  = '{32'h0020D193, 32'h80000000, 32'd0,        32'd2,        32'h20000000, 0, 1, 0, 2'b00, 2'b00, 1}; // srli
    vecs[4]  = '{32'h0000A193, 32'hFFFFFFFF, 32'd0,        32'd0,        32'd1,        0, 1, 0, 2'b00, 2'b00, 1}; // slti
    vecs[5]  = '{32'h40008193, 32'd10,       32'd0,        32'hFFFFFC00, 32'hFFFFFC0A, 0, 1, 0, 2'b00, 2'b00, 1}; // addi bit30
    vecs[6]  = '{32'h0040A183, 32'h100,      32'd0,        32'd4,        32'h104,      0, 1, 0, 2'b01, 2'b00, 1}; // lw
    vecs[7]  = '{32'h0020A223, 32'h100,      32'h55,       32'd4,        32'h104,      0, 0, 1, 2'b00, 2'b01, 1}; // sw
    vecs[8]  = '{BEQ,          32'd3,        32'd3,        32'd8,        32'd0,        1, 0, 0, 2'b00, 2'b10, 0}; // beq eq
    vecs[9]  = '{32'h0020B1B3, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd1,        0, 1, 0, 2'b00, 2'b00, 0}; // sltu
    vecs[10] = '{32'h0020A1B3, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        1, 1, 0, 2'b00, 2'b00, 0}; // slt
    vecs[11] = '{32'h0020C1B3, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h00000FF0, 0, 1, 0, 2'b00, 2'b00, 0}; // xor
    vecs[12] = '{32'h0020E1B3, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000FFF0, 0, 1, 0, 2'b00, 2'b00, 0}; // or
    vecs[13] = '{32'h0020F1B3, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000F000, 0, 1, 0, 2'b00, 2'b00, 0}; // and
    vecs[14] = '{32'h002091B3, 32'd1,        32'h21,       32'd0,        32'd2,        0, 1, 0, 2'b00, 2'b00, 0}; // sll uses [4:0]
    vecs[15] = '{32'h4020D1B3, 32'h80000000, 32'd4,        32'd0,        32'hF8000000, 0, 1, 0, 2'b00, 2'b00, 0}; // sra
    vecs[16] = '{32'h0000007F, 32'd5,        32'd7,        32'd3,        32'd12,       0, 0, 0, 2'b00, 2'b00, 0}; // illegal

    rst = 1'b0;
    instruction = NOP;
    rd1 = '0;
    rd2 = '0;
    imm_op = '0;

    // Reset held across edges, then released between edges.
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", pc, 32'h0);
    rst = 1'b1;
    #1;
    chk("release pc", pc, 32'h0);
    @(posedge clk);
    #1;
    chk("nop pc 4", pc, 32'h4);
    chk("nop pc_plus4", pc_plus4, 32'h8);
    @(posedge clk);
    #1;
    chk("nop pc 8", pc, 32'h8);

    for (int i = 0; i < NVEC; i++) begin
      instruction = vecs[i].instr;
      rd1 = vecs[i].a;
      rd2 = vecs[i].b;
      imm_op = vecs[i].imm;
      #1;
      chk($sformatf("v%0d alu_out", i), alu_out, vecs[i].alu);
      chk($sformatf("v%0d zero", i), {31'b0, zero}, {31'b0, vecs[i].z});
      chk($sformatf("v%0d reg_wr_en", i), {31'b0, reg_wr_en}, {31'b0, vecs[i].rw});
      chk($sformatf("v%0d mem_wr_en", i), {31'b0, mem_wr_en}, {31'b0, vecs[i].mw});
      chk($sformatf("v%0d result_src", i), {30'b0, result_src}, {30'b0, vecs[i].rs});
      chk($sformatf("v%0d imm_src", i), {30'b0, imm_src}, {30'b0, vecs[i].is});
      chk($sformatf("v%0d alu_src", i), {31'b0, alu_src}, {31'b0, vecs[i].as});
    end

    // BEQ taken
    go_pc(32'h10);
    instruction = BEQ;
    rd1 = 32'd3;
    rd2 = 32'd3;
    imm_op = 32'd8;
    @(posedge clk);
    #1;
    chk("beq taken pc", pc, 32'h18);

    // BEQ not taken
    go_pc(32'h10);
    instruction = BEQ;
    rd1 = 32'd3;
    rd2 = 32'd4;
    imm_op = 32'd8;
    #1;
    chk("beq ne zero", {31'b0, zero}, 32'd0);
    @(posedge clk);
    #1;
    chk("beq not taken pc", pc, 32'h14);

    // BNE with equal operands
    go_pc(32'h10);
    instruction = BNE;
    rd1 = 32'd3;
    rd2 = 32'd3;
    imm_op = 32'd8;
    @(posedge clk);
    #1;
    chk("bne not taken pc", pc, 32'h14);

    // BNE taken
    go_pc(32'h10);
    instruction = BNE;
    rd1 = 32'd3;
    rd2 = 32'd4;
    imm_op = 32'd8;
    @(posedge clk);
    #1;
    chk("bne taken pc", pc, 32'h18);

    // JAL from 0x20
    go_pc(32'h20);
    instruction = JAL;
    imm_op = 32'd8;
    #1;
    chk("jal pc_plus4", pc_plus4, 32'h24);
    chk("jal result_src", {30'b0, result_src}, 32'h2);
    @(posedge clk);
    #1;
    chk("jal pc", pc, 32'h28);

    // Illegal opcode: no writes, sequential PC even with a large immediate
    instruction = 32'h0000_007F;
    imm_op = 32'h100;
    #1;
    chk("illegal reg_wr_en", {31'b0, reg_wr_en}, 32'd0);
    chk("illegal mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    chk("illegal pc", pc, 32'h2C);

    // Asynchronous reset mid-run, no edge in between
    rst = 1'b0;
    #1;
    chk("async reset pc", pc, 32'h0);
    @(posedge clk);
    #1;
    chk("reset held pc", pc, 32'h0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_ctrl.md
Name: rv32i_exec_ctrl

Overview:
- Single-cycle RV32I execute/control slice: PC register with the +4 and branch-target adders, main/ALU decoder, and a 32-bit ALU with operand-B mux.
- Sits between instruction memory/sign-extension/register file (all external) and the writeback/data-memory path.
- The only state is the PC; everything else is combinational.

Parameters:
- DATA_WIDTH, 32, datapath/PC width. Only 32 is required to work.
- RESET_PC, 32'h0000_0000, PC value while reset is asserted.

Ports:
- clk  input  1  clock; PC updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- instruction  input  32  current instruction, fetched externally at pc.
- rd1  input  DATA_WIDTH  register file read data 1 (rs1).
- rd2  input  DATA_WIDTH  register file read data 2 (rs2).
- imm_op  input  DATA_WIDTH  sign-extended immediate, byte offset, already formatted per imm_src.
- pc  output  DATA_WIDTH  current program counter.
- pc_plus4  output  DATA_WIDTH  pc + 4.
- alu_out  output  DATA_WIDTH  ALU result; also the data-memory address.
- zero  output  1  1 when alu_out == 0.
- reg_wr_en  output  1  register file write enable.
- mem_wr_en  output  1  data memory write enable.
- result_src  output  2  writeback select: 00 ALU, 01 memory, 10 pc_plus4.
- imm_src  output  2  immediate format to the sign-extender: 00 I, 01 S, 10 B, 11 J.
- alu_src  output  1  ALU operand B select: 0 rd2, 1 imm_op.

Behaviour:
- Fields: opcode = instruction[6:0], funct3 = [14:12], funct7_5 = [30].
- PC reset: pc = RESET_PC immediately when rst = 0, held while low. First update is on the first rising clk after rst goes high.
- next_pc = pc_src ? (pc + imm_op) : (pc + 4). Both sums wrap modulo 2^32. pc loads next_pc every rising edge when rst = 1. No enable, no stall.
- pc_src = (beq & zero) | (bne & ~zero) | jal. Internal only.
- Decode by opcode (reg_wr_en, mem_wr_en, alu_src, imm_src, result_src, ALU op):
  - 0110011 R-type: 1, 0, 0, xx→00, 00, per funct3/funct7_5.
  - 0010011 I-ALU: 1, 0, 1, 00, 00, per funct3; funct7_5 used only for SRAI vs SRLI; ADDI never subtracts.
  - 0000011 LW: 1, 0, 1, 00, 01, ADD.
  - 0100011 SW: 0, 1, 1, 01, 00, ADD.
  - 1100011 branch: 0, 0, 0, 10, 00, SUB. funct3 000 = BEQ, 001 = BNE; other funct3 values never branch.
  - 1101111 JAL: 1, 0, 1, 11, 10, ADD (ALU result unused); pc_src = 1.
  - Any other opcode: all enables 0, alu_src 0, imm_src 00, result_src 00, pc_src 0, ALU ADD.
- ALU op from funct3: 000 ADD (SUB if R-type and funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (funct7_5), 110 OR, 111 AND.
- Shifts use opB[4:0]. SLT is signed, SLTU unsigned; both give 0 or 1.
- ADD/SUB wrap; no overflow flag. zero is derived from alu_out for every op.
- All outputs other than pc are purely combinational from instruction, rd1, rd2, imm_op and pc, including during reset.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode localparams;
  - alu_op_e enum, 4-bit: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001;
  - result_src and imm_src encodings.
- Natural sub-module: alu (opA, opB, alu_op → result, zero).
- The two PC adders are plain adder instances.

Test Plan:
- Reset: hold rst = 0 across edges, then release → pc = 0. Following edges with a NOP (0x00000013) → pc = 4, then 8.
- R-type: add x3,x1,x2 (0x002081B3), rd1 = 5, rd2 = 7 → alu_out = 12, reg_wr_en = 1, alu_src = 0, result_src = 00. Then sub (0x402081B3) → 0xFFFFFFFE.
- I-type/shift: srai (0x4020D193), rd1 = 0x80000000, imm_op = 2 → alu_out = 0xE0000000. srli (0x0020D193) → 0x20000000. slti with rd1 = -1, imm_op = 0 → 1.
- Load/store: lw (0x0040A183), rd1 = 0x100, imm_op = 4 → alu_out = 0x104, result_src = 01. sw (0x0020A223) → mem_wr_en = 1, reg_wr_en = 0, imm_src = 01.
- Branch: beq (0x00208463), pc = 0x10, imm_op = 8, rd1 = rd2 = 3 → zero = 1, next pc = 0x18. rd2 = 4 → pc = 0x14. bne with equal operands → pc = 0x14.
- JAL/illegal: jal (0x008000EF), pc = 0x20, imm_op = 8 → pc becomes 0x28, pc_plus4 = 0x24, result_src = 10. Opcode 0x7F → no writes, pc = pc + 4. Assert rst mid-run → pc = 0 without a clock edge.
